// File: rtl/sha256_header_sequencer.sv
// Splits an 80-byte header into padded SHA-256 blocks and drives a single-block core.
// Optionally re-hashes the first digest and returns the result over a valid/ready port.
module sha256_header_sequencer #(
  parameter int DOUBLE_HASH    = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [639:0] in_header,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_digest,
  output logic         timeout_err,
  output logic         sha_enable,
  output logic [511:0] sha_data,
  output logic [255:0] sha_chain,
  input  logic [255:0] sha_hash,
  input  logic         sha_hash_done,
  output logic [1:0]   dbg_state
);

  // Handshakes: a transfer happens on any clock edge where valid && ready are both high;
  // valid and its payload must stay stable until that edge, and ready never depends on valid.
  typedef enum logic [1:0] {IDLE, START, WAIT, OUT} state_t;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);
  localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  state_t         state, state_n;
  logic [1:0]     blk, blk_n;
  logic [127:0]   hdr_tail, hdr_tail_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic           in_ready_n, out_valid_n, timeout_err_n, sha_enable_n;
  logic [255:0]   out_digest_n, sha_chain_n;
  logic [511:0]   sha_data_n;

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      blk         <= 2'd0;
      hdr_tail    <= '0;
      cnt         <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_digest  <= '0;
      timeout_err <= 1'b0;
      sha_enable  <= 1'b0;
      sha_data    <= '0;
      sha_chain   <= '0;
    end else begin
      state       <= state_n;
      blk         <= blk_n;
      hdr_tail    <= hdr_tail_n;
      cnt         <= cnt_n;
      in_ready    <= in_ready_n;
      out_valid   <= out_valid_n;
      out_digest  <= out_digest_n;
      timeout_err <= timeout_err_n;
      sha_enable  <= sha_enable_n;
      sha_data    <= sha_data_n;
      sha_chain   <= sha_chain_n;
    end
  end

  always_comb begin
    state_n       = state;
    blk_n         = blk;
    hdr_tail_n    = hdr_tail;
    cnt_n         = cnt;
    in_ready_n    = in_ready;
    out_valid_n   = out_valid;
    out_digest_n  = out_digest;
    timeout_err_n = 1'b0;
    sha_enable_n  = 1'b0;
    sha_data_n    = sha_data;
    sha_chain_n   = sha_chain;

    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          hdr_tail_n   = in_header[127:0];
          sha_data_n   = in_header[639:128];
          sha_chain_n  = IV;
          blk_n        = 2'd1;
          in_ready_n   = 1'b0;
          sha_enable_n = 1'b1;
          state_n      = START;
        end
      end
      START: begin
        cnt_n   = '0;
        state_n = WAIT;
      end
      WAIT: begin
        if (sha_hash_done) begin
          sha_chain_n = sha_hash;
          if (blk == 2'd1) begin
            sha_data_n   = {hdr_tail, 32'h80000000, 288'h0, 64'd640};
            blk_n        = 2'd2;
            sha_enable_n = 1'b1;
            state_n      = START;
          end else if (blk == 2'd2 && DOUBLE_HASH != 0) begin
            // Second pass hashes the 32-byte digest from scratch, so it restarts from IV.
            sha_data_n   = {sha_hash, 32'h80000000, 160'h0, 64'd256};
            sha_chain_n  = IV;
            blk_n        = 2'd3;
            sha_enable_n = 1'b1;
            state_n      = START;
          end else begin
            out_digest_n = sha_hash;
            out_valid_n  = 1'b1;
            state_n      = OUT;
          end
        end else begin
          cnt_n = (cnt == TMAX) ? cnt : cnt + CW'(1);
          if (cnt_n == TMAX) begin
            timeout_err_n = 1'b1;
            in_ready_n    = 1'b1;
            state_n       = IDLE;
          end
        end
      end
      OUT: begin
        if (out_ready) begin
          out_valid_n = 1'b0;
          in_ready_n  = 1'b1;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
